// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo-N up/down counter and its prescaler.
//   CNT_UP / CNT_DOWN : encodings of the direction input (up_i).
//   clog2_min1()      : ceil(log2(n)), but never less than 1. It sizes the
//                       prescaler so that PRESCALE=1 still gets a legal
//                       one-bit register.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/module_prescaler.sv
// -----------------------------------------------------------------------------
// module_prescaler
// Divides enabled clock cycles by PRESCALE. The module produces one step
// indication every PRESCALE cycles in which en_i is high. The phase is held
// while en_i is low. A restart sends the phase back to zero.
//
// Parameters
//   PRESCALE  : number of enabled cycles per step (>= 1)
// Ports
//   clk       in  system clock, rising edge
//   rst       in  asynchronous reset, active-low
//   en_i      in  advance the phase this cycle
//   restart_i in  synchronous return of the phase to zero (highest priority)
//   tick      out high in the enabled cycle that completes a period
//                 (combinational; the parent registers the result)
// -----------------------------------------------------------------------------
module module_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic tick
);

  localparam int            PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_p0 <= '0;
    end else if (restart_i) begin
      phase_p0 <= '0;
    end else if (en_i) begin
      if (phase_p0 == LAST) begin
        phase_p0 <= '0;
      end else begin
        phase_p0 <= phase_p0 + PW'(1);
      end
    end
  end

  assign tick = en_i && (phase_p0 == LAST);

endmodule

// File: rtl/module_updown_counter.sv
// -----------------------------------------------------------------------------
// module_updown_counter
// Modulo-MODULUS up/down counter with an optional prescaler, synchronous clear
// and load, and registered step (tick_o) and wrap (tc_o) pulses.
// The priority order is rst, clear_i, load_i, then step.
//
// Configuration macro: UPDOWN_COUNTER_PRESCALER_EN
//   defined   : a module_prescaler instance divides enabled cycles by PRESCALE.
//   undefined : there is no prescaler. Every cycle with en_i=1 is a step cycle,
//               and PRESCALE is checked but otherwise ignored.
//
// Parameters
//   WIDTH     : count width
//   MODULUS   : count range is 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH
//   PRESCALE  : enabled cycles per step (>= 1)
// Ports
//   clk        in  system clock, rising edge
//   rst        in  asynchronous reset, active-low
//   en_i       in  enable; low freezes the prescaler and the count
//   up_i       in  direction (1 = up, 0 = down), sampled on the step cycle
//   clear_i    in  synchronous clear of the count and the prescaler
//   load_i     in  synchronous load of load_val_i (clamped to MODULUS-1)
//   load_val_i in  load value
//   count_o    out registered count
//   tick_o     out one-cycle pulse with every count step
//   tc_o       out one-cycle pulse with every wrap
// -----------------------------------------------------------------------------
module module_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 60,
  parameter int PRESCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             tc_o
);

  localparam int               EW      = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // MODULUS may equal 2**WIDTH, so the load comparison uses one extra bit.
  localparam logic [EW-1:0]    MOD_EXT = EW'(MODULUS);

  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
    $error("module_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("module_updown_counter: PRESCALE must be at least 1");
  end

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} >= MOD_EXT) begin
      return MAX_CNT;
    end
    return v;
  endfunction

  // ---- stage p0: step decision -------------------------------------------
  logic step_p0;

`ifdef UPDOWN_COUNTER_PRESCALER_EN
  logic presc_tick;

  // A clear or a load restarts the prescaler period.
  module_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .restart_i (clear_i | load_i),
    .tick      (presc_tick)
  );

  assign step_p0 = presc_tick;
`else
  assign step_p0 = en_i;
`endif

  logic [WIDTH-1:0] count_nxt;
  logic             tick_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] count_p1;
  logic             tick_p1;
  logic             tc_p1;

  // Wrap is detected by comparison against the bounds, never by carry, so a
  // non-power-of-two MODULUS wraps exactly.
  always_comb begin
    count_nxt = count_p1;
    tick_nxt  = 1'b0;
    tc_nxt    = 1'b0;
    if (clear_i) begin
      count_nxt = '0;
    end else if (load_i) begin
      count_nxt = clamp_load(load_val_i);
    end else if (step_p0) begin
      tick_nxt = 1'b1;
      case (up_i)
        CNT_UP: begin
          if (count_p1 == MAX_CNT) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_p1 + WIDTH'(1);
          end
        end
        CNT_DOWN: begin
          if (count_p1 == '0) begin
            count_nxt = MAX_CNT;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_p1 - WIDTH'(1);
          end
        end
      endcase
    end
  end

  // ---- stage p1: registered count and pulses -----------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_p1 <= '0;
      tick_p1  <= 1'b0;
      tc_p1    <= 1'b0;
    end else begin
      count_p1 <= count_nxt;
      tick_p1  <= tick_nxt;
      tc_p1    <= tc_nxt;
    end
  end

  assign count_o = count_p1;
  assign tick_o  = tick_p1;
  assign tc_o    = tc_p1;

endmodule

// File: tb/tb_module_updown_counter.sv
module tb_module_updown_counter;

  localparam int WIDTH    = 6;
  localparam int MODULUS  = 10;
  localparam int PRESCALE = 4;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
  localparam int P_EFF = PRESCALE;
`else
  localparam int P_EFF = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             clear = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_tc = 0;

  module_updown_counter #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .up_i       (up),
    .clear_i    (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (count),
    .tick_o     (tick),
    .tc_o       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It counts enabled cycles since the last restart, and it
  // steps the count modulo MODULUS each time P_EFF enabled cycles have passed.
  int m_count = 0;
  int m_phase = 0;
  int m_tick  = 0;
  int m_tc    = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0; m_phase = 0; m_tick = 0; m_tc = 0;
    end else begin
      m_tick = 0;
      m_tc   = 0;
      if (clear) begin
        m_count = 0;
        m_phase = 0;
      end else if (load) begin
        m_count = (int'(load_val) >= MODULUS) ? MODULUS - 1 : int'(load_val);
        m_phase = 0;
      end else if (en) begin
        m_phase = m_phase + 1;
        if (m_phase == P_EFF) begin
          m_phase = 0;
          m_tick  = 1;
          if (up) begin
            m_tc    = (m_count == MODULUS - 1) ? 1 : 0;
            m_count = (m_count + 1) % MODULUS;
          end else begin
            m_tc    = (m_count == 0) ? 1 : 0;
            m_count = (m_count + MODULUS - 1) % MODULUS;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("count", int'(count), m_count);
    check("tick", int'(tick), m_tick);
    check("tc", int'(tc), m_tc);
    n_tick += int'(tick);
    n_tc   += int'(tc);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    edges(3);
    check("rst_count", int'(count), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_tc", int'(tc), 0);

    // Count up from reset through a full wrap
    en = 1'b1; up = 1'b1; rst = 1'b1;
    n_tick = 0; n_tc = 0;
    edges(P_EFF);
    check("first_step_count", int'(count), 1);
    check("first_step_tick", int'(tick), 1);
    edges(9 * P_EFF);
    check("wrap_up_count", int'(count), 0);
    check("wrap_up_tc", int'(tc), 1);
    @(negedge clk); #1;
    check("ticks_per_wrap", n_tick, 10);
    check("tcs_per_wrap", n_tc, 1);

    // Count down from reset
    @(posedge clk); #1;
    rst = 1'b0; #1; rst = 1'b1; up = 1'b0;
    edges(P_EFF);
    check("down_first_count", int'(count), 9);
    check("down_first_tc", int'(tc), 1);
    edges(P_EFF);
    check("down_second_count", int'(count), 8);
    check("down_second_tc", int'(tc), 0);

    // Load mid-period, then resume stepping one full period later
    up = 1'b1; load = 1'b1; load_val = 6'd7;
    edges(1);
    load = 1'b0;
    check("load_count", int'(count), 7);
    check("load_tick", int'(tick), 0);
    edges(P_EFF);
    check("after_load_count", int'(count), 8);
    check("after_load_tick", int'(tick), 1);

    // Load is clamped; clear beats load
    load = 1'b1; load_val = 6'd12;
    edges(1);
    check("clamp_count", int'(count), 9);
    clear = 1'b1; load_val = 6'd5;
    edges(1);
    check("clear_over_load", int'(count), 0);
    load = 1'b0; clear = 1'b0;

    // Enable low freezes the prescaler and the count
    edges(P_EFF - 1);
    en = 1'b0;
    edges(5);
    check("frozen_count", int'(count), 0);
    check("frozen_tick", int'(tick), 0);
    en = 1'b1;
    edges(1);
    check("resume_count", int'(count), 1);
    check("resume_tick", int'(tick), 1);

    // Asynchronous reset mid-count, between edges
    load = 1'b1; load_val = 6'd4;
    edges(1);
    load = 1'b0;
    edges(P_EFF);
    check("pre_async_count", int'(count), 5);
    check("pre_async_tick", int'(tick), 1);
    #1 rst = 1'b0;
    #1;
    check("async_count", int'(count), 0);
    check("async_tick", int'(tick), 0);
    check("async_tc", int'(tc), 0);
    rst = 1'b1;

    // Random traffic against the model
    repeat (3000) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 199) != 0);
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      clear    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = WIDTH'($urandom_range(0, 63));
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
